// File: rtl/spi_frame_master_pkg.sv
// Shared definitions for the SPI register-frame initiator: FSM states,
// default frame width and the register addresses used on the frame bus.
package spi_frame_master_pkg;

  localparam int unsigned FRAME_BITS_DEFAULT = 16;

  localparam logic [7:0] REG_LED = 8'd7;
  localparam logic [7:0] REG_MUX = 8'd8;
  localparam logic [7:0] REG_DAC = 8'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_frame_master_half_tick.sv
// SCLK half-period divider: tick marks the last clk cycle of each
// CLK_DIV-cycle half-period; held at the start of a period while clear is high.
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// SPI initiator for one register frame per start: shifts tx_data out MSB first
// on MOSI while capturing MISO, with CS setup/hold and a CS-high gap after each frame.
module spi_frame_master
  import spi_frame_master_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  spi_cs,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned BW = $clog2(FRAME_BITS + 1);

  state_t                  state;
  state_t                  state_next;
  logic                    tick;
  logic                    last_bit;
  logic [FRAME_BITS-1:0]   tx_sr;
  logic [FRAME_BITS-1:0]   rx_sr;
  logic [BW-1:0]           bit_cnt;

  assign last_bit = (bit_cnt == BW'(FRAME_BITS));

  spi_half_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_half_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state == ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (start) state_next = ST_SETUP;
      ST_SETUP:    if (tick)  state_next = ST_SHIFT_HI;
      ST_SHIFT_HI: if (tick)  state_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (tick)  state_next = last_bit ? ST_HOLD : ST_SHIFT_HI;
      ST_HOLD:     if (tick)  state_next = ST_GAP;
      ST_GAP:      if (tick)  state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // tx_sr holds only the bits still to be sent, so its MSB is always the next MOSI bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            spi_cs   <= 1'b0;
            spi_mosi <= tx_data[FRAME_BITS-1];
            tx_sr    <= {tx_data[FRAME_BITS-2:0], 1'b0};
            rx_sr    <= '0;
            bit_cnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (tick) spi_clk <= 1'b1;
        end
        ST_SHIFT_HI: begin
          if (tick) begin
            spi_clk <= 1'b0;
            rx_sr   <= {rx_sr[FRAME_BITS-2:0], spi_miso};
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_SHIFT_LO: begin
          if (tick && !last_bit) begin
            spi_clk  <= 1'b1;
            spi_mosi <= tx_sr[FRAME_BITS-1];
            tx_sr    <= tx_sr << 1;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
            done     <= 1'b1;
            rx_data  <= rx_sr;
          end
        end
        ST_GAP: begin
          if (tick) busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench: a 16-bit/CLK_DIV=2 instance with a register-bank receiver
// and MISO loopback, plus an 8-bit/CLK_DIV=1 instance for the fast-clock case.
module tb_spi_frame_master;
  import spi_frame_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start_a = 1'b0;
  logic [15:0] tx_a    = '0;
  logic        busy_a, done_a, cs_a, sclk_a, mosi_a, miso_a;
  logic [15:0] rx_a;

  logic        start_b = 1'b0;
  logic [7:0]  tx_b    = '0;
  logic        busy_b, done_b, cs_b, sclk_b, mosi_b, miso_b;
  logic [7:0]  rx_b;

  assign miso_a = mosi_a;
  assign miso_b = mosi_b;

  always #5 clk = ~clk;

  spi_frame_master #(.FRAME_BITS(16), .CLK_DIV(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a), .busy(busy_a), .done(done_a),
    .rx_data(rx_a), .spi_cs(cs_a), .spi_clk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  spi_frame_master #(.FRAME_BITS(8), .CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .busy(busy_b), .done(done_b),
    .rx_data(rx_b), .spi_cs(cs_b), .spi_clk(sclk_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor and register-bank receiver for instance A (samples MOSI on falling SCLK)
  logic        cs_a_q = 1'b1, sclk_a_q = 1'b0, mosi_a_q = 1'b0;
  int unsigned cs_lo_run_a = 0, cs_lo_last_a = 0, cs_hi_run_a = 0, cs_hi_last_a = 0;
  int unsigned busy_run_a = 0, busy_last_a = 0, done_cnt_a = 0;
  int unsigned sclk_hi_run_a = 0, sclk_hi_last_a = 0, rises_a = 0, rises_last_a = 0;
  int unsigned mosi_viol_a = 0, rcv_cnt_a = 0;
  logic [15:0] rcv_sr_a = '0, rcv_word_a = '0;
  logic [7:0]  reg_led = '0, reg_mux = '0;
  logic [3:0]  reg_dac = '0;

  always @(negedge clk) begin
    if (cs_a === 1'b0) cs_lo_run_a++;
    else if (cs_lo_run_a != 0) begin cs_lo_last_a = cs_lo_run_a; cs_lo_run_a = 0; end
    if (cs_a === 1'b1) cs_hi_run_a++;
    else if (cs_hi_run_a != 0) begin cs_hi_last_a = cs_hi_run_a; cs_hi_run_a = 0; end
    if (busy_a === 1'b1) busy_run_a++;
    else if (busy_run_a != 0) begin busy_last_a = busy_run_a; busy_run_a = 0; end
    if (done_a === 1'b1) done_cnt_a++;
    if (sclk_a === 1'b1) sclk_hi_run_a++;
    else if (sclk_hi_run_a != 0) begin sclk_hi_last_a = sclk_hi_run_a; sclk_hi_run_a = 0; end
    if (sclk_a === 1'b1 && sclk_a_q === 1'b0) rises_a++;
    if (cs_a === 1'b0 && sclk_a_q === 1'b1 && sclk_a === 1'b0) begin
      if (mosi_a !== mosi_a_q) mosi_viol_a++;
      rcv_sr_a = {rcv_sr_a[14:0], mosi_a};
      rcv_cnt_a++;
    end
    if (cs_a === 1'b1 && cs_a_q === 1'b0) begin
      rcv_word_a   = rcv_sr_a;
      rises_last_a = rises_a;
      rises_a      = 0;
      if (rcv_cnt_a == 16) begin
        if (rcv_sr_a[15:8] == REG_LED) reg_led = rcv_sr_a[7:0];
        if (rcv_sr_a[15:8] == REG_MUX) reg_mux = rcv_sr_a[7:0];
        if (rcv_sr_a[15:8] == REG_DAC) reg_dac = rcv_sr_a[3:0];
      end
      rcv_cnt_a = 0;
    end
    cs_a_q = cs_a; sclk_a_q = sclk_a; mosi_a_q = mosi_a;
  end

  // Monitor for instance B
  logic        cs_b_q = 1'b1, sclk_b_q = 1'b0, mosi_b_q = 1'b0;
  int unsigned cs_lo_run_b = 0, cs_lo_last_b = 0, busy_run_b = 0, busy_last_b = 0;
  int unsigned done_cnt_b = 0, sclk_hi_run_b = 0, sclk_hi_last_b = 0;
  int unsigned rises_b = 0, rises_last_b = 0, rise_gap_b = 0, rise_gap_last_b = 0, mosi_viol_b = 0;

  always @(negedge clk) begin
    rise_gap_b++;
    if (cs_b === 1'b0) cs_lo_run_b++;
    else if (cs_lo_run_b != 0) begin cs_lo_last_b = cs_lo_run_b; cs_lo_run_b = 0; end
    if (busy_b === 1'b1) busy_run_b++;
    else if (busy_run_b != 0) begin busy_last_b = busy_run_b; busy_run_b = 0; end
    if (done_b === 1'b1) done_cnt_b++;
    if (sclk_b === 1'b1) sclk_hi_run_b++;
    else if (sclk_hi_run_b != 0) begin sclk_hi_last_b = sclk_hi_run_b; sclk_hi_run_b = 0; end
    if (sclk_b === 1'b1 && sclk_b_q === 1'b0) begin
      rises_b++;
      rise_gap_last_b = rise_gap_b;
      rise_gap_b = 0;
    end
    if (cs_b === 1'b0 && sclk_b_q === 1'b1 && sclk_b === 1'b0 && mosi_b !== mosi_b_q) mosi_viol_b++;
    if (cs_b === 1'b1 && cs_b_q === 1'b0) begin rises_last_b = rises_b; rises_b = 0; end
    cs_b_q = cs_b; sclk_b_q = sclk_b; mosi_b_q = mosi_b;
  end

  task automatic wait_done_a(input string tag);
    int unsigned n = 0;
    while (done_a !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check({tag, " done_a seen"}, done_a, 1);
  endtask

  task automatic wait_busy_a(input string tag, input logic level);
    int unsigned n = 0;
    while (busy_a !== level && n < 2000) begin @(negedge clk); n++; end
    check({tag, " busy_a level"}, busy_a, level);
  endtask

  task automatic wait_rcv_a(input string tag, input int unsigned bits);
    int unsigned n = 0;
    while (rcv_cnt_a != bits && n < 2000) begin @(negedge clk); n++; end
    check({tag, " receiver bit count"}, rcv_cnt_a, bits);
  endtask

  task automatic wait_done_b(input string tag);
    int unsigned n = 0;
    while (done_b !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check({tag, " done_b seen"}, done_b, 1);
  endtask

  task automatic wait_busy_b(input string tag, input logic level);
    int unsigned n = 0;
    while (busy_b !== level && n < 2000) begin @(negedge clk); n++; end
    check({tag, " busy_b level"}, busy_b, level);
  endtask

  task automatic send_a(input logic [15:0] data);
    tx_a    = data;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  logic [15:0] loop_vals [3] = '{16'hA5C3, 16'h0000, 16'hFFFF};
  logic [7:0]  b_vals    [2] = '{8'h96, 8'h5A};

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst cs_a", cs_a, 1);
    check("rst sclk_a", sclk_a, 0);
    check("rst mosi_a", mosi_a, 0);
    check("rst busy_a", busy_a, 0);
    check("rst done_a", done_a, 0);
    check("rst rx_a", rx_a, 0);
    check("rst cs_b", cs_b, 1);
    check("rst sclk_b", sclk_b, 0);

    // rst and start together: reset wins
    start_a = 1'b1;
    tx_a    = 16'h0755;
    @(negedge clk);
    check("rst+start busy_a", busy_a, 0);
    check("rst+start cs_a", cs_a, 1);
    start_a = 1'b0;
    rst     = 1'b0;
    repeat (2) @(negedge clk);
    check("idle after rst busy_a", busy_a, 0);

    // 1: register write to LED, tx_data changed right after acceptance
    send_a(16'h0705);
    tx_a = 16'hFFFF;
    check("t1 busy after accept", busy_a, 1);
    wait_done_a("t1");
    check("t1 rx_a at done", rx_a, 16'h0705);
    @(negedge clk);
    check("t1 done one cycle", done_a, 0);
    wait_busy_a("t1", 1'b0);
    repeat (3) @(negedge clk);
    check("t1 reg_led", reg_led, 8'h05);
    check("t1 cs low cycles", cs_lo_last_a, 68);
    check("t1 busy high cycles", busy_last_a, 70);
    check("t1 done count", done_cnt_a, 1);
    check("t1 sclk rises", rises_last_a, 16);
    check("t1 sclk high cycles", sclk_hi_last_a, 2);
    check("t1 mosi stable at fall", mosi_viol_a, 0);

    // 2: loopback patterns
    foreach (loop_vals[i]) begin
      send_a(loop_vals[i]);
      wait_done_a("t2");
      check("t2 loopback rx_a", rx_a, loop_vals[i]);
      wait_busy_a("t2", 1'b0);
      @(negedge clk);
    end
    check("t2 done count", done_cnt_a, 4);

    // 3: start during a frame is ignored
    send_a(16'h1234);
    wait_rcv_a("t3", 5);
    tx_a    = 16'hBEEF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a("t3");
    check("t3 rx_a first value", rx_a, 16'h1234);
    wait_busy_a("t3", 1'b0);
    repeat (60) @(negedge clk);
    check("t3 single frame", done_cnt_a, 5);
    check("t3 busy stays low", busy_a, 0);
    check("t3 receiver word", rcv_word_a, 16'h1234);

    // 4: reset at bit 8 aborts the frame
    send_a(16'h075A);
    wait_rcv_a("t4", 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4 cs_a after rst", cs_a, 1);
    check("t4 sclk_a after rst", sclk_a, 0);
    check("t4 busy_a after rst", busy_a, 0);
    check("t4 rx_a cleared", rx_a, 0);
    check("t4 done_a after rst", done_a, 0);
    repeat (100) @(negedge clk);
    check("t4 no done after abort", done_cnt_a, 5);
    check("t4 reg_led untouched", reg_led, 8'h05);
    send_a(16'h0706);
    wait_done_a("t4b");
    check("t4 clean frame rx_a", rx_a, 16'h0706);
    wait_busy_a("t4b", 1'b0);
    repeat (3) @(negedge clk);
    check("t4 reg_led new", reg_led, 8'h06);
    check("t4 cs low cycles", cs_lo_last_a, 68);
    check("t4 done count", done_cnt_a, 6);

    // 5: start held high gives two frames back to back
    tx_a    = 16'h0801;
    start_a = 1'b1;
    @(negedge clk);
    tx_a = 16'h0902;
    wait_busy_a("t5 first end", 1'b0);
    wait_busy_a("t5 second start", 1'b1);
    start_a = 1'b0;
    wait_done_a("t5");
    check("t5 rx_a second", rx_a, 16'h0902);
    wait_busy_a("t5 second end", 1'b0);
    repeat (3) @(negedge clk);
    check("t5 reg_mux", reg_mux, 8'h01);
    check("t5 reg_dac", reg_dac, 4'h2);
    check("t5 cs high gap", cs_hi_last_a, 3);
    check("t5 done count", done_cnt_a, 8);

    // 6: CLK_DIV=1, FRAME_BITS=8
    foreach (b_vals[i]) begin
      tx_b    = b_vals[i];
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      wait_done_b("t6");
      check("t6 loopback rx_b", rx_b, b_vals[i]);
      wait_busy_b("t6", 1'b0);
      repeat (3) @(negedge clk);
      check("t6 cs low cycles", cs_lo_last_b, 18);
      check("t6 busy high cycles", busy_last_b, 19);
      check("t6 sclk high cycles", sclk_hi_last_b, 1);
      check("t6 sclk period", rise_gap_last_b, 2);
      check("t6 sclk rises", rises_last_b, 8);
    end
    check("t6 mosi stable at fall", mosi_viol_b, 0);
    check("t6 done count", done_cnt_b, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
